// File: rtl/fifo_reader_pkg.sv
// Shared constants and types for the FIFO reader.
// With FIFO_READER_BLKCNT_EN defined, the reader also counts completed blocks.
package fifo_reader_pkg;

  // Default FIFO word width: one end-of-block flag on top of a 32-bit payload.
  localparam int WORD_WIDTH_DEF = 33;
  localparam int LAST_BIT       = WORD_WIDTH_DEF - 1;
  localparam int BLKCNT_WIDTH   = 16;

  // Buffer occupancy, legal values 0..2.
  typedef logic [1:0] occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_ONE   = 2'd1;
  localparam occ_t OCC_FULL  = 2'd2;

  // Words the reader is already committed to holding once this cycle's
  // downstream transfer is taken out: buffered plus in-flight minus leaving.
  // A transfer is only possible with a non-empty buffer, so no underflow.
  function automatic logic [2:0] committed_words(input occ_t occ,
                                                 input logic inflight,
                                                 input logic xfer);
    committed_words = {1'b0, occ} + {2'b00, inflight} - {2'b00, xfer};
  endfunction

endpackage

// File: rtl/fifo_reader_skid_buf2.sv
// Two-entry in-order buffer between the FIFO read port and the downstream
// handshake. The head entry drives the outputs directly from flops.
module skid_buf2
  import fifo_reader_pkg::*;
#(
  parameter int DATA_W = WORD_WIDTH_DEF - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              push_last_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o,
  output occ_t              occ_o
);

  logic [DATA_W-1:0] hd_data_q, hd_data_d;
  logic              hd_last_q, hd_last_d;
  logic [DATA_W-1:0] tl_data_q, tl_data_d;
  logic              tl_last_q, tl_last_d;
  occ_t              occ_q, occ_d;
  logic              valid_q, valid_d;

  // Next-state for head/tail entries and occupancy; the tail only ever
  // refills the head, so FIFO order is preserved.
  always_comb begin
    hd_data_d = hd_data_q;
    hd_last_d = hd_last_q;
    tl_data_d = tl_data_q;
    tl_last_d = tl_last_q;
    occ_d     = occ_q;
    unique case ({push_i, pop_i})
      2'b10: begin
        if (occ_q == OCC_EMPTY) begin
          hd_data_d = push_data_i;
          hd_last_d = push_last_i;
          occ_d     = OCC_ONE;
        end else begin
          tl_data_d = push_data_i;
          tl_last_d = push_last_i;
          occ_d     = OCC_FULL;
        end
      end
      2'b01: begin
        if (occ_q == OCC_FULL) begin
          hd_data_d = tl_data_q;
          hd_last_d = tl_last_q;
          occ_d     = OCC_ONE;
        end else begin
          occ_d = OCC_EMPTY;
        end
      end
      2'b11: begin
        // Occupancy unchanged: the pushed word takes the vacated slot.
        if (occ_q == OCC_FULL) begin
          hd_data_d = tl_data_q;
          hd_last_d = tl_last_q;
          tl_data_d = push_data_i;
          tl_last_d = push_last_i;
        end else begin
          hd_data_d = push_data_i;
          hd_last_d = push_last_i;
        end
      end
      default: ;
    endcase
    valid_d = (occ_d != OCC_EMPTY);
  end

  // Storage and occupancy registers; everything clears on reset so a
  // discarded stream leaves no trace on the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hd_data_q <= '0;
      hd_last_q <= 1'b0;
      tl_data_q <= '0;
      tl_last_q <= 1'b0;
      occ_q     <= OCC_EMPTY;
      valid_q   <= 1'b0;
    end else begin
      hd_data_q <= hd_data_d;
      hd_last_q <= hd_last_d;
      tl_data_q <= tl_data_d;
      tl_last_q <= tl_last_d;
      occ_q     <= occ_d;
      valid_q   <= valid_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = hd_data_q;
  assign last_o  = hd_last_q;
  assign occ_o   = occ_q;

endmodule

// File: rtl/fifo_reader.sv
// Pops words from a registered-flag FIFO (1-cycle read latency) and presents
// them on a valid/ready stream with full throughput and no word loss.
// Optional feature macro: FIFO_READER_BLKCNT_EN adds the blk_cnt output.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fifo_empty,
  output logic                    fifo_rd,
  input  logic [WORD_WIDTH-1:0]   fifo_rd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_WIDTH-2:0]   out_data,
`ifdef FIFO_READER_BLKCNT_EN
  output logic [BLKCNT_WIDTH-1:0] blk_cnt,
`endif
  output logic                    out_last
);

  logic inflight_q, inflight_d;
  logic xfer;
  occ_t occ;

  assign xfer = out_valid & out_ready;

  // Pop issue: only when the FIFO has data and the buffer is guaranteed a
  // free slot when the word lands next cycle. Held low during reset so the
  // first pop comes no earlier than the first cycle out of reset.
  always_comb begin
    fifo_rd    = 1'b0;
    inflight_d = 1'b0;
    if (rst_n && !fifo_empty && (committed_words(occ, inflight_q, xfer) < 3'd2)) begin
      fifo_rd = 1'b1;
    end
    inflight_d = fifo_rd;
  end

  // In-flight flag: a pop accepted this cycle delivers its word next cycle,
  // and that word is captured unconditionally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  skid_buf2 #(
    .DATA_W (WORD_WIDTH - 1)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (inflight_q),
    .push_data_i (fifo_rd_data[WORD_WIDTH-2:0]),
    .push_last_i (fifo_rd_data[WORD_WIDTH-1]),
    .pop_i       (xfer),
    .valid_o     (out_valid),
    .data_o      (out_data),
    .last_o      (out_last),
    .occ_o       (occ)
  );

`ifdef FIFO_READER_BLKCNT_EN
  logic [BLKCNT_WIDTH-1:0] blk_cnt_q, blk_cnt_d;

  // Completed-block counter: one per transferred end-of-block word, wrapping.
  always_comb begin
    blk_cnt_d = blk_cnt_q;
    if (xfer && out_last) begin
      blk_cnt_d = blk_cnt_q + 1'b1;
    end
  end

  // Block counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blk_cnt_q <= '0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
    end
  end

  assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: FIFO model + expected-word scoreboard.
module tb_fifo_reader;

  localparam int W = 33;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd;
  logic [W-1:0]  fifo_rd_data = '0;
  logic          out_valid;
  logic          out_ready;
  logic [W-2:0]  out_data;
  logic          out_last;
`ifdef FIFO_READER_BLKCNT_EN
  logic [15:0]   blk_cnt;
`endif

  fifo_reader #(.WORD_WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd      (fifo_rd),
    .fifo_rd_data (fifo_rd_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
`ifdef FIFO_READER_BLKCNT_EN
    .blk_cnt      (blk_cnt),
`endif
    .out_last     (out_last)
  );

  always #5 clk = ~clk;

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  int           xfer_cyc[$];
  int           cyc = 0;
  int           n_cmp = 0;
  int           n_fail = 0;
  int           pops_tot = 0, xfers_tot = 0;
  int           pops_rs = 0, xfers_rs = 0;
  int           idle_viol = 0;
  logic         idle_win = 1'b0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_word = '0;
  logic [W-1:0] last_xfer_word = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: pop on accepted read, data one cycle later, registered empty.
  always @(posedge clk) begin
    if (fifo_rd && !fifo_empty) fifo_rd_data <= fifo_q.pop_front();
    fifo_empty <= (fifo_q.size() == 0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: scoreboard on every transfer, plus pop-rule and hold checks.
  always @(negedge clk) begin
    if (!rst_n) begin
      pops_rs    = 0;
      xfers_rs   = 0;
      prev_stall = 1'b0;
    end else begin
      if (fifo_empty) check("rd_when_empty", {63'd0, fifo_rd}, 64'd0);
      if (fifo_rd && !fifo_empty) begin
        pops_tot++;
        pops_rs++;
      end
      if (prev_stall) check("hold_during_stall", {30'd0, out_valid, out_last, out_data},
                            {30'd0, 1'b1, prev_word});
      if (out_valid && out_ready) begin
        xfers_tot++;
        xfers_rs++;
        xfer_cyc.push_back(cyc);
        last_xfer_word = {out_last, out_data};
        if (exp_q.size() == 0) begin
          check("unexpected_xfer", {31'd0, out_last, out_data}, 64'hDEAD);
        end else begin
          check("xfer_word", {31'd0, out_last, out_data}, {31'd0, exp_q.pop_front()});
        end
      end
      if (fifo_rd && !fifo_empty)
        check("outstanding_le2", {63'd0, (pops_rs - xfers_rs) > 2}, 64'd0);
      if (idle_win && (fifo_rd || out_valid)) idle_viol++;
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_last, out_data};
    end
  end

  task automatic push_word(input logic [W-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    check(name, {63'd0, exp_q.size() != 0}, 64'd0);
  endtask

  initial begin
    int rd_c, v_c, p0, x0, n;
    logic toggling;

    // Reset with the FIFO preloaded: nothing may move while rst_n is low.
    rst_n = 1'b0;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) push_word(W'(i));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_fifo_rd", {63'd0, fifo_rd}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", {32'd0, out_data}, 64'd0);
    check("rst_out_last", {63'd0, out_last}, 64'd0);
`ifdef FIFO_READER_BLKCNT_EN
    check("rst_blk_cnt", {48'd0, blk_cnt}, 64'd0);
`endif

    // Preloaded 1..4 with out_ready=1: 2-cycle latency, back-to-back output.
    @(posedge clk); #1;
    rst_n = 1'b1;
    xfer_cyc.delete();
    rd_c = -1; v_c = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_rd && rd_c < 0) rd_c = cyc;
      if (out_valid && v_c < 0) v_c = cyc;
    end
    check("latency_rd_to_valid", 64'(v_c - rd_c), 64'd2);
    wait_drain("drain_preload", 20);
    check("preload_xfer_count", 64'(xfer_cyc.size()), 64'd4);
    if (xfer_cyc.size() == 4)
      for (int i = 0; i < 3; i++)
        check("back_to_back", 64'(xfer_cyc[i+1] - xfer_cyc[i]), 64'd1);

    // Stall with 8 words queued: exactly 2 pops, head word held.
    out_ready = 1'b0;
    p0 = pops_tot; x0 = xfers_tot;
    for (int i = 0; i < 8; i++) push_word(W'(32'h11 + i));
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("stall_pops", 64'(pops_tot - p0), 64'd2);
    check("stall_fifo_rd", {63'd0, fifo_rd}, 64'd0);
    check("stall_head", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'h11});
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain("drain_stall", 40);
    check("stall_xfer_count", 64'(xfers_tot - x0), 64'd8);

    // out_ready alternating 1,0 with 16 words streaming.
    x0 = xfers_tot;
    for (int i = 0; i < 16; i++) push_word(W'(32'h100 + i));
    toggling = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 80) begin
      out_ready = toggling;
      toggling = ~toggling;
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b1;
    wait_drain("drain_toggle", 10);
    check("toggle_xfer_count", 64'(xfers_tot - x0), 64'd16);

    // End-of-block word.
    push_word(33'h1_0000_00AA);
    wait_drain("drain_last", 20);
    check("last_word", {31'd0, last_xfer_word}, {31'd0, 33'h1_0000_00AA});
`ifdef FIFO_READER_BLKCNT_EN
    check("blk_cnt_after_last", {48'd0, blk_cnt}, 64'd1);
`endif

    // Reset with one word buffered and one in flight: both are discarded.
    out_ready = 1'b0;
    p0 = pops_tot;
    push_word(W'(32'h21));
    push_word(W'(32'h22));
    push_word(W'(32'h23));
    n = 0;
    while ((pops_tot - p0) < 2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("pre_reset_pops", 64'(pops_tot - p0), 64'd2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    @(negedge clk);
    check("midrst_fifo_rd", {63'd0, fifo_rd}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    x0 = xfers_tot;
    out_ready = 1'b1;
    wait_drain("drain_after_reset", 20);
    check("after_reset_xfers", 64'(xfers_tot - x0), 64'd1);

    // Empty FIFO for 50 cycles: no pops, no output.
    @(negedge clk);
    idle_win = 1'b1;
    repeat (50) @(negedge clk);
    idle_win = 1'b0;
    check("idle_activity", 64'(idle_viol), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
